ped_request_latch: RTL and testbench
====================================

// Module: ped_request_latch
// PURPOSE
//  Front end for the two crosswalk push-buttons; sits directly upstream of traffic_light_top.
//  Per button it synchronizes the raw asynchronous input, debounces it and detects the press
//  edge, then holds a sticky walk request (north_ped_sig / west_ped_sig) until the controller
//  acknowledges that the walk phase was served.
//  It also reports which pending request arrived first, so the controller serves them in order.
// PARAMETERS
//  SYNC_STAGES      2  synchronizer flops per button (>=2)
//  DEBOUNCE_CYCLES  4  consecutive stable synchronized cycles required to change debounced level (>=1)
// PORTS
//  clk            in   1  single system clock; all state on rising edge
//  reset          in   1  asynchronous, active-high reset
//  north_btn      in   1  raw north crosswalk button, asynchronous, active-high
//  west_btn       in   1  raw west crosswalk button, asynchronous, active-high
//  north_ack      in   1  from controller: north walk phase served, clear north request (1-cycle pulse or level)
//  west_ack       in   1  from controller: west walk phase served, clear west request
//  north_ped_sig  out  1  sticky north walk request -> traffic_light_top.north_ped_sig
//  west_ped_sig   out  1  sticky west walk request -> traffic_light_top.west_ped_sig
//  first_is_west  out  1  1 = west request is the older pending one
//  debug          out  1  OR of both debounced button levels
// BEHAVIOUR
//  Reset (async assert, sync-free release): all sync flops, debounced levels, counters, requests,
//   first_is_west and debug = 0; debounce FSMs in STABLE_LO.
//  Synchronizer: SYNC_STAGES-flop chain per button; s = last stage.
//  Debounce FSM per button, states STABLE_LO, CNT_HI, STABLE_HI, CNT_LO; counter width $clog2(DEBOUNCE_CYCLES+1).
//   STABLE_LO: s=1 -> CNT_HI, cnt=1 (DEBOUNCE_CYCLES=1: go straight to STABLE_HI).
//   CNT_HI: s=0 -> STABLE_LO, cnt=0 (glitch rejected).
//   CNT_HI: s=1 and cnt==DEBOUNCE_CYCLES-1 -> STABLE_HI.
//   CNT_HI: otherwise s=1 -> cnt+1.
//   STABLE_HI / CNT_LO: mirror image toward STABLE_LO.
//   Debounced level = 1 in STABLE_HI and CNT_LO.
//  Press edge: asserted combinationally on the transition into STABLE_HI.
//   The request flop sets on that same clock edge.
//   Latency: raw high stable from sampling edge 0 -> request visible after SYNC_STAGES+DEBOUNCE_CYCLES edges (default 6).
//  Request flop: set on press edge; else clear on ack; else hold.
//   Press edge and ack in the same cycle: set wins (new press is not lost).
//   Ack with no pending request: no effect.
//   A held button yields one press edge only; re-request needs release (debounced low) then press.
//  Ordering (first_is_west):
//   - only west pending -> 1; only north -> 0; none -> 0.
//   - both pending -> the older request; if both set on the same edge, north is older (0).
//   - registered; updates on the same edge as the request flops.
//  debug: registered OR of the two debounced levels.
//  Reset mid-debounce or with requests pending: everything clears immediately; no request survives.
// STRUCTURE
//  Shared package: debounce state encoding (2-bit localparams STABLE_LO=0, CNT_HI=1, STABLE_HI=2,
//   CNT_LO=3) and the clog2 counter-width helper.
//  One sub-module, ped_debounce (sync chain + FSM + press-edge output), instantiated twice.
//  Top holds the two request flops, the ordering flop and debug.
// TESTING
//  1 Reset held 5 cycles, buttons toggling -> all outputs 0 throughout; release -> still 0.
//  2 north_btn=1 held -> north_ped_sig=1 exactly 6 edges after first sample; first_is_west=0; debug=1 same edge.
//  3 west_btn high 3 cycles then low -> no request; counter back to 0; debug stays 0.
//  4 north pending, west pressed later -> first_is_west stays 0.
//    Then north_ack pulse -> north_ped_sig=0 and first_is_west=1 on the next edge.
//  5 Button held through west_ack -> west_ped_sig clears and stays 0.
//    Release >=4 cycles, press again -> request re-sets.
//    Ack coinciding with a new press edge -> west_ped_sig stays 1.
//  6 Reset asserted mid-CNT_HI and with both requests set -> outputs 0 asynchronously.
//    After release, a fresh press takes the full 6-edge latency.

Source files
------------

// File: rtl/ped_request_latch_pkg.sv
// Shared definitions for the crosswalk request front end: the debounce state
// encoding and the helper that sizes the debounce counter.
package ped_request_latch_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CNT_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CNT_LO    = 2'd3
    } deb_state_e;

    // Counter must hold values up to DEBOUNCE_CYCLES inclusive.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/ped_request_latch_debounce.sv
// One push-button channel: synchronizer chain, debounce FSM and a one-cycle
// press pulse raised when the debounced level rises.
module ped_debounce
    import ped_request_latch_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_level_next,
    output logic o_press
);

    localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    deb_state_e             r_state;
    deb_state_e             w_stateNext;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cntNext;
    logic                   w_level;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync  <= '0;
            r_state <= STABLE_LO;
            r_cnt   <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_btn};
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        case (r_state)
            STABLE_LO: begin
                if (w_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_stateNext = STABLE_HI;
                        w_cntNext   = '0;
                    end else begin
                        w_stateNext = CNT_HI;
                        w_cntNext   = ONE;
                    end
                end
            end
            CNT_HI: begin
                if (!w_s) begin
                    w_stateNext = STABLE_LO;
                    w_cntNext   = '0;
                end else if (r_cnt == LAST) begin
                    w_stateNext = STABLE_HI;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext = r_cnt + ONE;
                end
            end
            STABLE_HI: begin
                if (!w_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_stateNext = STABLE_LO;
                        w_cntNext   = '0;
                    end else begin
                        w_stateNext = CNT_LO;
                        w_cntNext   = ONE;
                    end
                end
            end
            CNT_LO: begin
                if (w_s) begin
                    w_stateNext = STABLE_HI;
                    w_cntNext   = '0;
                end else if (r_cnt == LAST) begin
                    w_stateNext = STABLE_LO;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext = r_cnt + ONE;
                end
            end
            default: begin
                w_stateNext = STABLE_LO;
                w_cntNext   = '0;
            end
        endcase
    end

    // A bounce back from CNT_LO to STABLE_HI is not a new press, so the pulse
    // keys on the debounced level rising rather than on entering STABLE_HI alone.
    assign w_level      = (r_state == STABLE_HI) || (r_state == CNT_LO);
    assign o_level_next = (w_stateNext == STABLE_HI) || (w_stateNext == CNT_LO);
    assign o_press      = o_level_next && !w_level;

endmodule

// File: rtl/ped_request_latch.sv
// Crosswalk request front end: two debounced buttons feeding sticky walk
// requests, an arrival-order flag and a debug level indicator.
module ped_request_latch
    import ped_request_latch_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic north_btn,
    input  logic west_btn,
    input  logic north_ack,
    input  logic west_ack,
    output logic north_ped_sig,
    output logic west_ped_sig,
    output logic first_is_west,
    output logic debug
);

    logic w_northLevelNext;
    logic w_westLevelNext;
    logic w_northPress;
    logic w_westPress;
    logic w_northReqNext;
    logic w_westReqNext;
    logic w_firstNext;
    logic r_northReq;
    logic r_westReq;
    logic r_firstIsWest;
    logic r_debug;

    ped_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_north (
        .clk          (clk),
        .reset        (reset),
        .i_btn        (north_btn),
        .o_level_next (w_northLevelNext),
        .o_press      (w_northPress)
    );

    ped_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_west (
        .clk          (clk),
        .reset        (reset),
        .i_btn        (west_btn),
        .o_level_next (w_westLevelNext),
        .o_press      (w_westPress)
    );

    // A press in the same cycle as an ack wins, so a fresh request is never lost.
    assign w_northReqNext = w_northPress || (r_northReq && !north_ack);
    assign w_westReqNext  = w_westPress  || (r_westReq  && !west_ack);

    // With both pending, the one already held is older; a tie goes to north.
    always_comb begin
        w_firstNext = w_westReqNext;
        if (w_northReqNext && w_westReqNext) begin
            if (r_northReq && r_westReq) begin
                w_firstNext = r_firstIsWest;
            end else begin
                w_firstNext = r_westReq && !r_northReq;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_northReq    <= 1'b0;
            r_westReq     <= 1'b0;
            r_firstIsWest <= 1'b0;
            r_debug       <= 1'b0;
        end else begin
            r_northReq    <= w_northReqNext;
            r_westReq     <= w_westReqNext;
            r_firstIsWest <= w_firstNext;
            r_debug       <= w_northLevelNext || w_westLevelNext;
        end
    end

    assign north_ped_sig = r_northReq;
    assign west_ped_sig  = r_westReq;
    assign first_is_west = r_firstIsWest;
    assign debug         = r_debug;

endmodule

// File: tb/tb_ped_request_latch.sv
// Directed and randomized checks of ped_request_latch against a behavioural
// model built from run lengths, arrival timestamps and a sample delay line.
module tb_ped_request_latch;

    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic northBtn  = 1'b0;
    logic westBtn   = 1'b0;
    logic northAck  = 1'b0;
    logic westAck   = 1'b0;
    logic northPedSig;
    logic westPedSig;
    logic firstIsWest;
    logic debug;

    int nChecks = 0;
    int nErrors = 0;

    bit qN[$];
    bit qW[$];
    bit mNLvl, mWLvl, mNReq, mWReq, mFirst, mDebug;
    int mNRun, mWRun, mNSince, mWSince, mEdge;
    bit rN, rW;

    always #5 clk = ~clk;

    ped_request_latch #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .north_btn     (northBtn),
        .west_btn      (westBtn),
        .north_ack     (northAck),
        .west_ack      (westAck),
        .north_ped_sig (northPedSig),
        .west_ped_sig  (westPedSig),
        .first_is_west (firstIsWest),
        .debug         (debug)
    );

    task automatic modelReset();
        qN.delete();
        qW.delete();
        for (int i = 0; i < SYNC_STAGES; i++) begin
            qN.push_back(1'b0);
            qW.push_back(1'b0);
        end
        mNLvl = 0; mWLvl = 0; mNRun = 0; mWRun = 0;
        mNReq = 0; mWReq = 0; mFirst = 0; mDebug = 0;
        mNSince = 0; mWSince = 0;
    endtask

    // Level flips once the sample has disagreed with it for DEBOUNCE_CYCLES in a row.
    task automatic debModel(input bit s, input bit lvl, input int run,
                            output bit lvlO, output int runO, output bit press);
        lvlO  = lvl;
        runO  = 0;
        press = 0;
        if (s != lvl) begin
            runO = run + 1;
            if (runO >= DEBOUNCE_CYCLES) begin
                lvlO  = s;
                runO  = 0;
                press = s;
            end
        end
    endtask

    task automatic modelEdge();
        bit sN, sW, pN, pW;
        sN = qN.pop_front();
        sW = qW.pop_front();
        qN.push_back(northBtn);
        qW.push_back(westBtn);
        debModel(sN, mNLvl, mNRun, mNLvl, mNRun, pN);
        debModel(sW, mWLvl, mWRun, mWLvl, mWRun, pW);
        if (pN) begin
            if (!mNReq) mNSince = mEdge;
            mNReq = 1;
        end else if (northAck) begin
            mNReq = 0;
        end
        if (pW) begin
            if (!mWReq) mWSince = mEdge;
            mWReq = 1;
        end else if (westAck) begin
            mWReq = 0;
        end
        mFirst = mWReq && (!mNReq || (mWSince < mNSince));
        mDebug = mNLvl || mWLvl;
        mEdge++;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, ".north_ped_sig"}, northPedSig, mNReq);
        chk({tag, ".west_ped_sig"},  westPedSig,  mWReq);
        chk({tag, ".first_is_west"}, firstIsWest, mFirst);
        chk({tag, ".debug"},         debug,       mDebug);
    endtask

    task automatic applyStimulus(input logic nb, input logic wb, input logic na, input logic wa,
                                 input string tag);
        northBtn = nb;
        westBtn  = wb;
        northAck = na;
        westAck  = wa;
        @(posedge clk);
        if (reset) modelReset();
        else       modelEdge();
        #1;
        checkOutput(tag);
    endtask

    initial begin
        modelReset();
        mEdge = 0;
        #1;
        checkOutput("t1.async");

        // Reset held with buttons toggling, then released
        for (int i = 0; i < 5; i++) applyStimulus(i[0], !i[0], i[1], i[0], "t1.hold");
        reset = 1'b0;
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, "t1.release");

        // Short west glitch is rejected
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, "t3.glitch");
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, "t3.after");
        chk("t3.no_west_req", westPedSig, 1'b0);
        chk("t3.debug_low", debug, 1'b0);

        // North press latency
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1, 0, 0, 0, "t2.press");
            if (i == 5) begin
                chk("t2.edge5_north", northPedSig, 1'b0);
                chk("t2.edge5_debug", debug, 1'b0);
            end
        end
        chk("t2.edge6_north", northPedSig, 1'b1);
        chk("t2.edge6_first", firstIsWest, 1'b0);
        chk("t2.edge6_debug", debug, 1'b1);

        // West joins later; north stays older until acked
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 0, "t4.west");
        chk("t4.west_set", westPedSig, 1'b1);
        chk("t4.first_north", firstIsWest, 1'b0);
        applyStimulus(1, 1, 1, 0, "t4.ack");
        chk("t4.north_clear", northPedSig, 1'b0);
        chk("t4.first_west", firstIsWest, 1'b1);
        applyStimulus(1, 1, 0, 0, "t4.held");
        chk("t4.no_rerequest", northPedSig, 1'b0);

        // West held through ack, release, re-press, ack on press edge
        applyStimulus(1, 1, 0, 1, "t5.ack");
        chk("t5.west_clear", westPedSig, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, "t5.held");
        chk("t5.west_stays0", westPedSig, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, "t5.release");
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(0, 1, 0, 0, "t5.repress");
            if (i == 5) chk("t5.edge5_west", westPedSig, 1'b0);
        end
        chk("t5.west_reset", westPedSig, 1'b1);
        applyStimulus(0, 0, 0, 1, "t5.ack2");
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 0, "t5.release2");
        for (int i = 1; i <= 6; i++) applyStimulus(0, 1, 0, (i == 6), "t5.ackpress");
        chk("t5.set_wins", westPedSig, 1'b1);
        applyStimulus(0, 1, 0, 0, "t5.after");

        // Both pending, north mid-debounce, then async reset
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 0, "t6.north");
        chk("t6.first_west", firstIsWest, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 0, "t6.nrel");
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, "t6.midcnt");
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        chk("t6.async_north", northPedSig, 1'b0);
        chk("t6.async_west", westPedSig, 1'b0);
        chk("t6.async_debug", debug, 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, "t6.inreset");
        reset = 1'b0;
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, "t6.idle");
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1, 0, 0, 0, "t6.fresh");
            if (i == 5) chk("t6.edge5_north", northPedSig, 1'b0);
        end
        chk("t6.edge6_north", northPedSig, 1'b1);

        // Randomized traffic against the model
        rN = 1;
        rW = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(5) == 0) rN = !rN;
            if ($urandom_range(5) == 0) rW = !rW;
            applyStimulus(rN, rW, ($urandom_range(7) == 0), ($urandom_range(7) == 0), "rand");
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
